pe_mac_seq: RTL



---
 rtl/pe_mac_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_seq.sv
// pe_mac_seq: output-stationary systolic processing element.
// Signed fixed-point multiply-accumulate over a run-time run length, with
// valid-tagged operands, a saturating accumulator and registered
// pass-through of both operands to the neighbouring PEs.
module pe_mac_seq #(
  parameter int I_BITS   = 8,
  parameter int GUARD    = 2,
  parameter int MAX_K    = 16,
  parameter int LEN_BITS = $clog2(MAX_K + 1),
  parameter int ACC_BITS = 2 * I_BITS + GUARD
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [LEN_BITS-1:0] i_len,
  input  logic [I_BITS-1:0]   i_a,
  input  logic                i_a_valid,
  input  logic [I_BITS-1:0]   i_b,
  input  logic                i_b_valid,
  output logic [I_BITS-1:0]   o_a,
  output logic                o_a_valid,
  output logic [I_BITS-1:0]   o_b,
  output logic                o_b_valid,
  output logic [ACC_BITS-1:0] o_c,
  output logic [LEN_BITS-1:0] o_count,
  output logic                o_done,
  output logic                o_sat,
  output logic                o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  state_t              state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [LEN_BITS-1:0] count_q, count_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                sat_q, sat_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [I_BITS-1:0]   a_q, a_d;
  logic [I_BITS-1:0]   b_q, b_d;
  logic                a_valid_q, a_valid_d;
  logic                b_valid_q, b_valid_d;

  logic signed [2*I_BITS-1:0] prod_s;
  logic [ACC_BITS:0]          sum_s;
  logic                       ovf_s;
  logic [ACC_BITS-1:0]        acc_next_s;
  logic [LEN_BITS-1:0]        count_inc_s;
  logic                       beat_s;
  logic                       mismatch_s;

  // Operand pass-through: a plain one-cycle delay, independent of the FSM.
  always_comb begin
    a_d       = i_a;
    b_d       = i_b;
    a_valid_d = i_a_valid;
    b_valid_d = i_b_valid;
  end

  // Product, one-bit-wider sum and saturating clamp of the accumulator.
  always_comb begin
    prod_s      = $signed(i_a) * $signed(i_b);
    sum_s       = {acc_q[ACC_BITS-1], acc_q}
                + {{(ACC_BITS + 1 - 2*I_BITS){prod_s[2*I_BITS-1]}}, prod_s};
    ovf_s       = sum_s[ACC_BITS] ^ sum_s[ACC_BITS-1];
    count_inc_s = count_q + LEN_BITS'(1);
    beat_s      = i_a_valid & i_b_valid;
    mismatch_s  = i_a_valid ^ i_b_valid;
    if (ovf_s) begin
      acc_next_s = sum_s[ACC_BITS] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next_s = sum_s[ACC_BITS-1:0];
    end
  end

  // Run-control FSM next state and accumulator/status updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    sat_d   = sat_q;
    err_d   = err_q;
    if (i_start) begin
      // Start (or restart) wins over any beat presented in the same cycle.
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
      err_d   = 1'b0;
      len_d   = i_len;
      if (i_len != '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (beat_s) begin
            acc_d   = acc_next_s;
            count_d = count_inc_s;
            if (ovf_s) begin
              sat_d = 1'b1;
            end else begin
              sat_d = sat_q;
            end
            if (count_inc_s == len_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else if (mismatch_s) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  // State, accumulator and status registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Forwarding registers towards the right and lower neighbours.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign o_a       = a_q;
  assign o_a_valid = a_valid_q;
  assign o_b       = b_q;
  assign o_b_valid = b_valid_q;
  assign o_c       = acc_q;
  assign o_count   = count_q;
  assign o_done    = done_q;
  assign o_sat     = sat_q;
  assign o_err     = err_q;

endmodule
